// File: rtl/cpu_pkg.sv
// Shared CPU types and address-space constants for the front end.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a. Macro defaults mirror cpu/constants.svh when it is not pulled in.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef INST_COUNT
`define INST_COUNT 256
`endif
`ifndef INST_COUNT_L2
`define INST_COUNT_L2 8
`endif

package cpu_pkg;

   // Program counter sequencing states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } pc_state_t;

   // Byte size of instruction memory; every fetch address lies below it
   localparam logic [`BIT_WIDTH-1:0] PC_LIMIT = `BIT_WIDTH'(`INST_COUNT * 4);

   // Keeps the in-range word address bits, drops byte offset and high bits
   localparam logic [`BIT_WIDTH-1:0] PC_MASK =
      (PC_LIMIT - `BIT_WIDTH'(1)) & ~(`BIT_WIDTH'(3));

   // Fold an arbitrary byte address onto a word-aligned in-range address
   function automatic logic [`BIT_WIDTH-1:0] pc_mask(input logic [`BIT_WIDTH-1:0] addr);
      return addr & PC_MASK;
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter sequencer: drives the fetch address, tracks the fetched pc, handles redirects.
// Latency: issue -> inst_valid next cycle; branch -> target valid 2 cycles later.
// Backpressure: stall replays the held instruction and freezes pc; PC_ALIGN_CHECK_EN enables align_err.
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [`BIT_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   enable,
   input  logic                   stall,
   input  logic                   branch_valid,
   input  logic [`BIT_WIDTH-1:0]  branch_target,
   output logic [`BIT_WIDTH-1:0]  fetch_pc,
   output logic                   fetch_enable,
   output logic [`BIT_WIDTH-1:0]  inst_pc,
   output logic                   inst_valid,
   output logic                   align_err
);

   pc_state_t             state_q;
   pc_state_t             state_d;
   logic [`BIT_WIDTH-1:0] pc_q;
   logic [`BIT_WIDTH-1:0] inst_pc_q;
   logic [`BIT_WIDTH-1:0] pc_inc;
   logic [`BIT_WIDTH-1:0] pc_seq;
   logic                  replay;
   logic                  issue;

   assign inst_valid   = (state_q == RUN);
   assign fetch_enable = enable;
   assign inst_pc      = inst_pc_q;

   // A stalled valid instruction is re-presented to the fetcher by re-driving its address
   assign replay   = inst_valid & stall;
   assign fetch_pc = replay ? inst_pc_q : pc_q;
   assign issue    = enable & ~branch_valid & ~replay;

   // Sequential successor wraps to zero at the top of instruction memory
   assign pc_inc = pc_q + `BIT_WIDTH'(4);
   assign pc_seq = (pc_inc == PC_LIMIT) ? '0 : pc_inc;

   // Next-state: disable dominates, then redirect, otherwise keep running
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else if (branch_valid) begin
         state_d = REDIRECT;
      end else begin
         state_d = RUN;
      end
   end

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Address registers: a branch only retargets pc_q, an issue advances both
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pc_q      <= RESET_PC;
         inst_pc_q <= RESET_PC;
      end else if (branch_valid) begin
         pc_q      <= pc_mask(branch_target);
      end else if (issue) begin
         inst_pc_q <= fetch_pc;
         pc_q      <= pc_seq;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic align_q;

   // Sticky flag for any branch target that needed masking
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         align_q <= 1'b0;
      end else if (branch_valid &&
                   ((branch_target[1:0] != 2'b00) || (branch_target >= PC_LIMIT))) begin
         align_q <= 1'b1;
      end
   end

   assign align_err = align_q;
`else
   assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with an instruction-level reference model and per-cycle compare.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef INST_COUNT
`define INST_COUNT 256
`endif

module tb_pc_unit;

   localparam logic [`BIT_WIDTH-1:0] LIM = `BIT_WIDTH'(`INST_COUNT * 4);
   localparam logic [`BIT_WIDTH-1:0] RST = '0;
`ifdef PC_ALIGN_CHECK_EN
   localparam logic [`BIT_WIDTH-1:0] EXP_ERR = `BIT_WIDTH'(1);
`else
   localparam logic [`BIT_WIDTH-1:0] EXP_ERR = '0;
`endif

   logic                  clk = 1'b0;
   logic                  nreset;
   logic                  enable;
   logic                  stall;
   logic                  branch_valid;
   logic [`BIT_WIDTH-1:0] branch_target;
   logic [`BIT_WIDTH-1:0] fetch_pc;
   logic                  fetch_enable;
   logic [`BIT_WIDTH-1:0] inst_pc;
   logic                  inst_valid;
   logic                  align_err;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_on      = 1'b0;

   // Reference model: what the fetcher currently holds and what comes next
   logic                  m_valid;
   logic [`BIT_WIDTH-1:0] m_inst_pc;
   logic [`BIT_WIDTH-1:0] m_next;
   logic                  m_err;

   always #5 clk = ~clk;

   pc_unit #(.RESET_PC(RST)) dut (
      .clk           (clk),
      .nreset        (nreset),
      .enable        (enable),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .fetch_pc      (fetch_pc),
      .fetch_enable  (fetch_enable),
      .inst_pc       (inst_pc),
      .inst_valid    (inst_valid),
      .align_err     (align_err)
   );

   task automatic check(input string name, input logic [`BIT_WIDTH-1:0] act,
                        input logic [`BIT_WIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update: a branch always flushes, disable flushes, a stalled valid instruction holds
   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_valid   = 1'b0;
         m_inst_pc = RST;
         m_next    = RST;
         m_err     = 1'b0;
      end else if (branch_valid) begin
`ifdef PC_ALIGN_CHECK_EN
         if ((branch_target % 4 != 0) || (branch_target >= LIM)) m_err = 1'b1;
`endif
         m_next  = (branch_target - (branch_target % 4)) % LIM;
         m_valid = 1'b0;
      end else if (!enable) begin
         m_valid = 1'b0;
      end else if (!(m_valid && stall)) begin
         m_inst_pc = m_next;
         m_next    = (m_next + 4) % LIM;
         m_valid   = 1'b1;
      end
   end

   // Per-cycle comparison of all outputs against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         check("inst_valid", `BIT_WIDTH'(inst_valid), `BIT_WIDTH'(m_valid));
         check("inst_pc", inst_pc, m_inst_pc);
         check("fetch_pc", fetch_pc, (m_valid && stall) ? m_inst_pc : m_next);
         check("fetch_enable", `BIT_WIDTH'(fetch_enable), `BIT_WIDTH'(enable));
         check("align_err", `BIT_WIDTH'(align_err), `BIT_WIDTH'(m_err));
      end
   end

   // Apply one cycle of inputs and return just after the capturing edge
   task automatic step(input logic en, input logic st, input logic br,
                       input logic [`BIT_WIDTH-1:0] tgt);
      enable        = en;
      stall         = st;
      branch_valid  = br;
      branch_target = tgt;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic                  en;
      logic                  st;
      logic                  br;
      logic [`BIT_WIDTH-1:0] tgt;
   } vec_t;

   vec_t mix [10];

   initial begin
      mix[0] = '{1'b1, 1'b1, 1'b0, 32'h0};
      mix[1] = '{1'b1, 1'b1, 1'b1, 32'h20};
      mix[2] = '{1'b1, 1'b1, 1'b0, 32'h0};
      mix[3] = '{1'b0, 1'b1, 1'b0, 32'h0};
      mix[4] = '{1'b0, 1'b0, 1'b1, 32'h30};
      mix[5] = '{1'b1, 1'b0, 1'b0, 32'h0};
      mix[6] = '{1'b1, 1'b0, 1'b0, 32'h0};
      mix[7] = '{1'b1, 1'b1, 1'b0, 32'h0};
      mix[8] = '{1'b0, 1'b1, 1'b0, 32'h0};
      mix[9] = '{1'b1, 1'b0, 1'b0, 32'h0};

      nreset = 1'b0; enable = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
      @(posedge clk);
      #1;
      chk_on = 1'b1;
      check("rst inst_valid", `BIT_WIDTH'(inst_valid), '0);
      check("rst inst_pc", inst_pc, 32'h0);
      check("rst fetch_pc", fetch_pc, 32'h0);
      check("rst align_err", `BIT_WIDTH'(align_err), '0);
      @(posedge clk);
      #1;
      nreset = 1'b1;

      // Boot: first issued address is the reset pc
      step(1, 0, 0, 0);
      check("boot valid", `BIT_WIDTH'(inst_valid), `BIT_WIDTH'(1));
      check("boot pc0", inst_pc, 32'h0);
      step(1, 0, 0, 0);
      check("boot pc1", inst_pc, 32'h4);
      step(1, 0, 0, 0);
      check("boot pc2", inst_pc, 32'h8);

      // Branch to 0x40 from 0x8: one invalid cycle, then target
      step(1, 0, 1, 32'h40);
      check("br bubble valid", `BIT_WIDTH'(inst_valid), '0);
      check("br bubble pc", inst_pc, 32'h8);
      step(1, 0, 0, 0);
      check("br target valid", `BIT_WIDTH'(inst_valid), `BIT_WIDTH'(1));
      check("br target pc", inst_pc, 32'h40);

      // Three stalled cycles at 0x10 then release
      step(1, 0, 1, 32'h10);
      step(1, 0, 0, 0);
      check("pre-stall pc", inst_pc, 32'h10);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0);
         check("stall inst_pc", inst_pc, 32'h10);
         check("stall fetch_pc", fetch_pc, 32'h10);
         check("stall valid", `BIT_WIDTH'(inst_valid), `BIT_WIDTH'(1));
      end
      step(1, 0, 0, 0);
      check("stall release pc", inst_pc, 32'h14);

      // Wrap at the top of instruction memory
      step(1, 0, 1, 32'h3F8);
      step(1, 0, 0, 0);
      check("wrap pc 3f8", inst_pc, 32'h3F8);
      check("wrap fetch 3fc", fetch_pc, 32'h3FC);
      step(1, 0, 0, 0);
      check("wrap pc 3fc", inst_pc, 32'h3FC);
      check("wrap fetch 0", fetch_pc, 32'h0);
      step(1, 0, 0, 0);
      check("wrap pc 0", inst_pc, 32'h0);

      // Misaligned and out-of-range targets are masked; flag follows build option
      step(1, 0, 1, 32'h42);
      step(1, 0, 0, 0);
      check("misalign pc", inst_pc, 32'h40);
      check("misalign err", `BIT_WIDTH'(align_err), EXP_ERR);
      step(1, 0, 0, 0);
      check("err sticky", `BIT_WIDTH'(align_err), EXP_ERR);
      step(1, 0, 1, 32'h404);
      step(1, 0, 0, 0);
      check("range pc", inst_pc, 32'h4);

      // Enable drop holds position; resume at next unfetched address
      step(0, 0, 0, 0);
      check("disable valid", `BIT_WIDTH'(inst_valid), '0);
      check("disable fetch_en", `BIT_WIDTH'(fetch_enable), '0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("resume pc", inst_pc, 32'h8);

      // Mixed stall / branch / enable sequence
      foreach (mix[i]) step(mix[i].en, mix[i].st, mix[i].br, mix[i].tgt);
      check("mix final pc", inst_pc, 32'h38);

      // Asynchronous reset while redirecting
      step(1, 0, 1, 32'h80);
      #2;
      nreset = 1'b0;
      #1;
      check("arst valid", `BIT_WIDTH'(inst_valid), '0);
      check("arst inst_pc", inst_pc, RST);
      check("arst fetch_pc", fetch_pc, RST);
      check("arst align_err", `BIT_WIDTH'(align_err), '0);
      branch_valid = 1'b0;
      @(posedge clk);
      #1;
      nreset = 1'b1;
      step(1, 0, 0, 0);
      check("post-arst pc", inst_pc, RST);
      check("post-arst valid", `BIT_WIDTH'(inst_valid), `BIT_WIDTH'(1));
      step(1, 0, 0, 0);
      check("post-arst pc1", inst_pc, 32'h4);

      @(negedge clk);
      #1;
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
